pixel_stream_src: RTL and testbench

PIXEL_STREAM_SRC -- requirements
Module: pixel_stream_src

---
 rtl/pixel_stream_pkg.sv | 16 +
 rtl/pixel_stream_src_xy_counter.sv | 51 +++++
 rtl/pixel_stream_src.sv | 150 +++++++++++++++
 tb/tb_pixel_stream_src.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_pkg.sv
// Shared types and constants for the pixel stream source.
package pixel_stream_pkg;

    localparam int PIX_W           = 12;
    localparam int CNT_W           = 10;
    localparam int H_ACTIVE_DEF    = 640;
    localparam int V_ACTIVE_DEF    = 480;
    localparam int FLUSH_LINES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_stream_src_xy_counter.sv
// Raster x/y counter: x wraps at H_ACTIVE and carries into y.
// The last-pixel flags describe the coordinate currently held, i.e. the
// coordinate the next emitted pixel will carry.
module xy_counter
    import pixel_stream_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int FLUSH_LINES = FLUSH_LINES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             x_last,
    output logic             frame_last,
    output logic             flush_last
);

    localparam logic [CNT_W-1:0] X_MAX       = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_FRAME_MAX = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] Y_FLUSH_MAX = CNT_W'(V_ACTIVE + FLUSH_LINES - 1);

    // Advance x each enabled cycle; wrap x and step y at end of line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= y + CNT_W'(1);
            end else begin
                x <= x + CNT_W'(1);
            end
        end
    end

    // Decode end-of-line, last active pixel and last flush pixel.
    always_comb begin
        x_last     = (x == X_MAX);
        frame_last = x_last && (y == Y_FRAME_MAX);
        flush_last = x_last && (y == Y_FLUSH_MAX);
    end

endmodule

// File: rtl/pixel_stream_src.sv
// Pixel stream source: accepts one frame of upstream pixels after start,
// re-times them with raster coordinates, then emits FLUSH_LINES lines of
// zero pixels so downstream row buffers drain.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for start; no pixels accepted or emitted
//   ST_STREAM | accepting upstream pixels, one output per accepted pixel
//   ST_FLUSH  | emitting zero pixels every cycle until the last flush line
//
// Every output is a register. The state returns to IDLE in the same edge
// that raises frame_done, so busy (still high in that cycle) gates start.
module pixel_stream_src
    import pixel_stream_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int FLUSH_LINES = FLUSH_LINES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_r,
    input  logic [PIX_W-1:0] in_g,
    input  logic [PIX_W-1:0] in_b,
    output logic             valid,
    output logic [CNT_W-1:0] x_cntr,
    output logic [CNT_W-1:0] y_cntr,
    output logic [PIX_W-1:0] pixel_r,
    output logic [PIX_W-1:0] pixel_g,
    output logic [PIX_W-1:0] pixel_b,
    output logic             sof,
    output logic             eol,
    output logic             busy,
    output logic             frame_done
);

    state_t           state;
    state_t           state_next;
    logic             emit;
    logic             pix_zero;
    logic             cnt_clr;
    logic             done_next;
    logic [CNT_W-1:0] cnt_x;
    logic [CNT_W-1:0] cnt_y;
    logic             x_last;
    logic             frame_last;
    logic             flush_last;

    xy_counter #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .FLUSH_LINES (FLUSH_LINES)
    ) u_xy (
        .clk        (clk),
        .rst        (rst),
        .en         (emit),
        .clr        (cnt_clr),
        .x          (cnt_x),
        .y          (cnt_y),
        .x_last     (x_last),
        .frame_last (frame_last),
        .flush_last (flush_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle emit decisions.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        pix_zero   = 1'b0;
        cnt_clr    = 1'b0;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !busy) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (in_valid) begin
                    emit = 1'b1;
                    if (frame_last) begin
                        state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                emit     = 1'b1;
                pix_zero = 1'b1;
                if (flush_last) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output registers; coordinates and colour hold between emitted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b0;
            x_cntr     <= '0;
            y_cntr     <= '0;
            pixel_r    <= '0;
            pixel_g    <= '0;
            pixel_b    <= '0;
        end else begin
            valid      <= emit;
            sof        <= emit && (cnt_x == '0) && (cnt_y == '0);
            eol        <= emit && x_last;
            frame_done <= done_next;
            busy       <= (state_next != ST_IDLE) || done_next;
            in_ready   <= (state_next == ST_STREAM);
            if (emit) begin
                x_cntr <= cnt_x;
                y_cntr <= cnt_y;
                if (pix_zero) begin
                    pixel_r <= '0;
                    pixel_g <= '0;
                    pixel_b <= '0;
                end else begin
                    pixel_r <= in_r;
                    pixel_g <= in_g;
                    pixel_b <= in_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_stream_src.sv
// Testbench for pixel_stream_src. The main instance uses full line width
// with a short frame so a complete frame plus flush fits a short run; a
// second instance uses the 4x3 geometry.
module tb_pixel_stream_src;

    localparam int H  = 640;
    localparam int V  = 20;
    localparam int F  = 2;
    localparam int P  = H * V;
    localparam int T  = P + F * H;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_r, in_g, in_b;
    logic        valid;
    logic [9:0]  x_cntr, y_cntr;
    logic [11:0] pixel_r, pixel_g, pixel_b;
    logic        sof, eol, busy, frame_done;

    logic        s_start;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [11:0] s_in_r, s_in_g, s_in_b;
    logic        s_valid;
    logic [9:0]  s_x_cntr, s_y_cntr;
    logic [11:0] s_pixel_r, s_pixel_g, s_pixel_b;
    logic        s_sof, s_eol, s_busy, s_frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    pixel_stream_src #(.H_ACTIVE(H), .V_ACTIVE(V), .FLUSH_LINES(F)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .valid(valid), .x_cntr(x_cntr), .y_cntr(y_cntr),
        .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
        .sof(sof), .eol(eol), .busy(busy), .frame_done(frame_done)
    );

    pixel_stream_src #(.H_ACTIVE(4), .V_ACTIVE(3), .FLUSH_LINES(2)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_r(s_in_r), .in_g(s_in_g), .in_b(s_in_b),
        .valid(s_valid), .x_cntr(s_x_cntr), .y_cntr(s_y_cntr),
        .pixel_r(s_pixel_r), .pixel_g(s_pixel_g), .pixel_b(s_pixel_b),
        .sof(s_sof), .eol(s_eol), .busy(s_busy), .frame_done(s_frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [35:0] px(input int k);
        logic [11:0] r, g, b;
        int k7;
        k7 = k * 7;
        r = k[11:0] ^ 12'h5A5;
        g = k7[11:0];
        b = ~k[11:0];
        return {r, g, b};
    endfunction

    typedef struct {
        logic        start;
        logic        in_valid;
        logic [11:0] r, g, b;
        logic        e_valid;
        logic        e_ready;
        logic        e_busy;
        logic        e_sof;
        logic        e_eol;
        logic [9:0]  e_x, e_y;
        logic [11:0] e_r, e_g, e_b;
    } vec_t;

    vec_t tv [0:6];

    initial begin
        int e_x, e_y, e_v, e_d, e_sof, e_eol, e_rdy, e_busy, e_fd;
        int n_eol, n_done, n_valid, pass_ok, zero_ok, done_at;
        logic [35:0] p;

        tv[0] = '{1'b0, 1'b1, 12'hF00, 12'hF01, 12'hF02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 12'h000, 12'h000, 12'h000};
        tv[1] = '{1'b1, 1'b1, 12'hF11, 12'hF12, 12'hF13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'h000, 12'h000, 12'h000};
        tv[2] = '{1'b0, 1'b1, 12'hA01, 12'hA02, 12'hA03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'hA01, 12'hA02, 12'hA03};
        tv[3] = '{1'b0, 1'b0, 12'hE01, 12'hE02, 12'hE03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'h000, 12'h000, 12'h000};
        tv[4] = '{1'b0, 1'b1, 12'hB01, 12'hB02, 12'hB03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd1, 10'd0, 12'hB01, 12'hB02, 12'hB03};
        tv[5] = '{1'b0, 1'b1, 12'hC01, 12'hC02, 12'hC03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd2, 10'd0, 12'hC01, 12'hC02, 12'hC03};
        tv[6] = '{1'b0, 1'b0, 12'hD01, 12'hD02, 12'hD03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'h000, 12'h000, 12'h000};

        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; in_r = '0; in_g = '0; in_b = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_in_r = '0; s_in_g = '0; s_in_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_xy", int'({x_cntr, y_cntr}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Idle pixel ignored, start, then gap pattern 1,0,1,1,0.
        for (int i = 0; i < 7; i++) begin
            start = tv[i].start; in_valid = tv[i].in_valid;
            in_r = tv[i].r; in_g = tv[i].g; in_b = tv[i].b;
            @(negedge clk);
            chk($sformatf("tv%0d_valid", i), int'(valid), int'(tv[i].e_valid));
            chk($sformatf("tv%0d_in_ready", i), int'(in_ready), int'(tv[i].e_ready));
            chk($sformatf("tv%0d_busy", i), int'(busy), int'(tv[i].e_busy));
            chk($sformatf("tv%0d_sof", i), int'(sof), int'(tv[i].e_sof));
            chk($sformatf("tv%0d_eol", i), int'(eol), int'(tv[i].e_eol));
            if (tv[i].e_valid) begin
                chk($sformatf("tv%0d_x", i), int'(x_cntr), int'(tv[i].e_x));
                chk($sformatf("tv%0d_y", i), int'(y_cntr), int'(tv[i].e_y));
                chk($sformatf("tv%0d_pix", i), int'({pixel_r, pixel_g, pixel_b}),
                    int'({tv[i].e_r, tv[i].e_g, tv[i].e_b}));
            end
        end
        start = 1'b0;

        // Continue to 1000 accepted pixels, then reset mid-stream.
        e_x = 0; e_v = 0; e_d = 0;
        for (int j = 3; j < 1000; j++) begin
            in_valid = 1'b1;
            p = px(j);
            {in_r, in_g, in_b} = p;
            @(negedge clk);
            if (valid !== 1'b1) e_v++;
            if ({x_cntr, y_cntr} !== {10'(j % H), 10'(j / H)}) e_x++;
            if ({pixel_r, pixel_g, pixel_b} !== p) e_d++;
        end
        chk("ms_valid_errs", e_v, 0);
        chk("ms_xy_errs", e_x, 0);
        chk("ms_data_errs", e_d, 0);
        chk("ms_last_x", int'(x_cntr), 999 % H);
        #2 rst = 1'b1;
        #1;
        chk("ms_rst_valid", int'(valid), 0);
        chk("ms_rst_in_ready", int'(in_ready), 0);
        chk("ms_rst_busy", int'(busy), 0);
        chk("ms_rst_flags", int'({sof, eol, frame_done}), 0);
        chk("ms_rst_xy", int'({x_cntr, y_cntr}), 0);
        chk("ms_rst_pix", int'({pixel_r, pixel_g, pixel_b}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ms_idle_in_ready", int'(in_ready), 0);
        chk("ms_idle_valid", int'(valid), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        p = px(7);
        {in_r, in_g, in_b} = p;
        @(negedge clk);
        chk("ms_new_valid", int'(valid), 1);
        chk("ms_new_xy", int'({x_cntr, y_cntr}), 0);
        chk("ms_new_sof", int'(sof), 1);
        chk("ms_new_pix", int'({pixel_r, pixel_g, pixel_b}), int'(p));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        // Continuous frame with stray start pulses.
        start = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("frm_arm_busy", int'(busy), 1);
        chk("frm_arm_in_ready", int'(in_ready), 1);
        chk("frm_arm_valid", int'(valid), 0);
        e_x = 0; e_y = 0; e_v = 0; e_d = 0; e_sof = 0; e_eol = 0;
        e_rdy = 0; e_busy = 0; e_fd = 0; n_eol = 0; n_done = 0;
        for (int k = 0; k < T; k++) begin
            start = (k == 50);
            in_valid = 1'b1;
            p = px(k);
            {in_r, in_g, in_b} = p;
            @(negedge clk);
            if (valid !== 1'b1) e_v++;
            if (x_cntr !== 10'(k % H)) e_x++;
            if (y_cntr !== 10'(k / H)) e_y++;
            if (sof !== (k == 0)) e_sof++;
            if (eol !== ((k % H) == H - 1)) e_eol++;
            if (frame_done !== (k == T - 1)) e_fd++;
            if (busy !== 1'b1) e_busy++;
            if (in_ready !== (k < P - 1)) e_rdy++;
            if ({pixel_r, pixel_g, pixel_b} !== ((k < P) ? p : 36'd0)) e_d++;
            if (eol) n_eol++;
            if (frame_done) n_done++;
            if (k == 0) begin
                chk("frm_first_xy", int'({x_cntr, y_cntr}), 0);
                chk("frm_first_sof", int'(sof), 1);
            end
            if (k == P - 1) begin
                chk("frm_last_real_x", int'(x_cntr), H - 1);
                chk("frm_last_real_y", int'(y_cntr), V - 1);
            end
            if (k == T - 1) begin
                chk("frm_done_x", int'(x_cntr), H - 1);
                chk("frm_done_y", int'(y_cntr), V + F - 1);
                chk("frm_done_flag", int'(frame_done), 1);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("frm_after_busy", int'(busy), 0);
        chk("frm_after_valid", int'(valid), 0);
        chk("frm_after_in_ready", int'(in_ready), 0);
        chk("frm_after_done", int'(frame_done), 0);
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0 || valid !== 1'b0) e_busy++;
        end
        chk("frm_valid_errs", e_v, 0);
        chk("frm_x_errs", e_x, 0);
        chk("frm_y_errs", e_y, 0);
        chk("frm_sof_errs", e_sof, 0);
        chk("frm_eol_errs", e_eol, 0);
        chk("frm_done_errs", e_fd, 0);
        chk("frm_busy_errs", e_busy, 0);
        chk("frm_in_ready_errs", e_rdy, 0);
        chk("frm_data_errs", e_d, 0);
        chk("frm_eol_count", n_eol, V + F);
        chk("frm_done_count", n_done, 1);
        in_valid = 1'b0;

        // Small geometry: 12 passthrough pixels then 8 flush pixels.
        s_start = 1'b1; s_in_valid = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        n_valid = 0; pass_ok = 0; zero_ok = 0; n_eol = 0; n_done = 0; done_at = 0;
        for (int c = 0; c < 30; c++) begin
            s_in_r = 12'(c + 1); s_in_g = 12'(c + 2); s_in_b = 12'(c + 3);
            @(negedge clk);
            if (s_valid) begin
                if (n_valid < 12) begin
                    if ({s_pixel_r, s_pixel_g, s_pixel_b} ==
                        {12'(n_valid + 1), 12'(n_valid + 2), 12'(n_valid + 3)}) pass_ok++;
                end else if ({s_pixel_r, s_pixel_g, s_pixel_b} == 36'd0) begin
                    zero_ok++;
                end
                n_valid++;
                if (s_eol) n_eol++;
                if (s_frame_done) begin
                    n_done++;
                    done_at = n_valid;
                end
            end
        end
        s_in_valid = 1'b0;
        chk("small_valid_count", n_valid, 20);
        chk("small_passthrough", pass_ok, 12);
        chk("small_zero", zero_ok, 8);
        chk("small_eol_count", n_eol, 5);
        chk("small_done_at", done_at, 20);
        chk("small_done_count", n_done, 1);
        chk("small_busy_end", int'(s_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
